// File: rtl/pf_ddr4_dqs_tx_pkg.sv
// Shared types and constants for the DDR4 DQS write-strobe sequencer.
// Holds the state encoding, the fixed DQS/OE words and the preamble pattern lookup.
package pf_ddr4_dqs_tx_pkg;

    // One state per kind of word the lane can put on the DQS pins.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        BURST = 2'd2,
        POST  = 2'd3
    } dqs_state_e;

    // A TX word and its matching OE word, travelling together.
    typedef struct packed {
        logic [7:0] tx;
        logic [3:0] oe;
    } dqs_word_t;

    localparam logic [7:0] DQS_IDLE_WORD  = 8'h00;
    localparam logic [7:0] DQS_BURST_WORD = 8'h55;
    localparam logic [7:0] DQS_POST_WORD  = 8'h00;
    localparam logic [3:0] DQS_OE_OFF     = 4'h0;
    localparam logic [3:0] DQS_OE_FULL    = 4'hF;
    localparam logic [3:0] DQS_POST_OE    = 4'b0001;

    // Preamble word for a given preamble length in tCK. A 2 tCK preamble
    // drives the last two UI pairs and carries one early rising edge in UI 4;
    // the 1 tCK preamble only drives the final UI pair low.
    function automatic dqs_word_t pre_word(input int unsigned tck);
        dqs_word_t w;
        case (tck)
            32'd2: begin
                w.tx = 8'h10;
                w.oe = 4'b1100;
            end
            default: begin
                w.tx = 8'h00;
                w.oe = 4'b1000;
            end
        endcase
        return w;
    endfunction

    // Word that the IOD must see while the sequencer sits in a given state.
    function automatic dqs_word_t state_word(input dqs_state_e st, input int unsigned tck);
        dqs_word_t w;
        case (st)
            PRE: begin
                w = pre_word(tck);
            end
            BURST: begin
                w.tx = DQS_BURST_WORD;
                w.oe = DQS_OE_FULL;
            end
            POST: begin
                w.tx = DQS_POST_WORD;
                w.oe = DQS_POST_OE;
            end
            default: begin
                w.tx = DQS_IDLE_WORD;
                w.oe = DQS_OE_OFF;
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pf_ddr4_dqs_tx_strobe_gen.sv
// DQS write-strobe sequencer for one DDR4 byte lane (8:1 serialisation).
// Turns write-burst requests into per-cycle DQS TX/OE words with preamble,
// seamless back-to-back bursts and postamble. All outputs are registered.
// Optional build macro: DQS_TX_ODT_CTRL_EN enables the DQS input ODT request
// path driven from RD_WINDOW; without it ODT_EN_0 is held low.
import pf_ddr4_dqs_tx_pkg::*;

module pf_ddr4_dqs_tx_strobe_gen #(
    parameter int unsigned LEN_W        = 4,
    parameter int unsigned PREAMBLE_TCK = 1
) (
    input  logic             FAB_CLK,
    input  logic             TX_SYNC_RST,
    input  logic             WR_START,
    input  logic [LEN_W-1:0] WR_LEN,
    input  logic             RD_WINDOW,
    output logic [7:0]       TX_DATA_0,
    output logic [3:0]       OE_DATA_0,
    output logic             ODT_EN_0,
    output logic             BUSY,
    output logic             WR_ERR
);

    dqs_state_e       state_q;
    dqs_state_e       state_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic [7:0]       tx_q;
    logic [7:0]       tx_d;
    logic [3:0]       oe_q;
    logic [3:0]       oe_d;
    logic             odt_q;
    logic             odt_d;
    logic             busy_q;
    logic             busy_d;
    logic             err_q;
    logic             err_d;

    logic             len_nz_s;
    logic             last_word_s;
    logic             slot_open_s;
    logic             accept_s;
    logic             reject_s;
    dqs_word_t        word_s;

    // Decide whether a request this cycle can be taken: a non-zero length
    // arriving while idle, in postamble, or on the final burst word.
    always_comb begin
        len_nz_s    = (WR_LEN != {LEN_W{1'b0}});
        last_word_s = (state_q == BURST) && (cnt_q <= LEN_W'(1));
        slot_open_s = (state_q == IDLE) || (state_q == POST) || last_word_s;
        accept_s    = WR_START & len_nz_s & slot_open_s;
        reject_s    = WR_START & ~accept_s;
    end

    // State register, down-counter and registered outputs with synchronous reset.
    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            state_q <= IDLE;
            cnt_q   <= {LEN_W{1'b0}};
            tx_q    <= 8'h00;
            oe_q    <= 4'h0;
            odt_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            oe_q    <= oe_d;
            odt_q   <= odt_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next-state and counter: the counter holds the number of burst words
    // still to send, including the one currently on the outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = PRE;
                    cnt_d   = WR_LEN;
                end else begin
                    state_d = IDLE;
                end
            end
            PRE: begin
                state_d = BURST;
            end
            BURST: begin
                if (cnt_q > LEN_W'(1)) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end else if (accept_s) begin
                    // Seamless continuation: keep toggling, no post/pre.
                    state_d = BURST;
                    cnt_d   = WR_LEN;
                end else begin
                    state_d = POST;
                    cnt_d   = {LEN_W{1'b0}};
                end
            end
            POST: begin
                if (accept_s) begin
                    state_d = PRE;
                    cnt_d   = WR_LEN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {LEN_W{1'b0}};
            end
        endcase
    end

    // Output words follow the next state so the registered outputs line up
    // with the state register; the error pulse flags a rejected request.
    always_comb begin
        word_s = state_word(state_d, PREAMBLE_TCK);
        tx_d   = word_s.tx;
        oe_d   = word_s.oe;
        busy_d = (state_d != IDLE);
        err_d  = reject_s;
    end

`ifdef DQS_TX_ODT_CTRL_EN
    // ODT is only requested when the strobe is quiet now and stays quiet next
    // cycle, so it drops with the first driven word and returns one cycle
    // after OE has gone back to zero.
    always_comb begin
        odt_d = RD_WINDOW & (state_d == IDLE) & ~accept_s & (state_q == IDLE);
    end
`else
    logic rd_window_unused_s;
    assign rd_window_unused_s = RD_WINDOW;

    // Without the ODT feature the input termination request is never raised.
    always_comb begin
        odt_d = 1'b0;
    end
`endif

    assign TX_DATA_0 = tx_q;
    assign OE_DATA_0 = oe_q;
    assign ODT_EN_0  = odt_q;
    assign BUSY      = busy_q;
    assign WR_ERR    = err_q;

endmodule
